// File: rtl/uart_rx_pkg.sv
// Shared UART frame constants and receiver state encodings.
// Frame format is 8N1, LSB first, idle high, matching the transmitter.
package uart_rx_pkg;

  localparam int DATA_BITS_N      = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START_BIT  = 3'd1;
  localparam logic [2:0] DATA_BITS  = 3'd2;
  localparam logic [2:0] STOP_BIT   = 3'd3;
  localparam logic [2:0] BREAK_WAIT = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both stages reset to 1 so a reset never looks like a falling edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample the pre-edge values and form a true two-stage pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: resynchronises the line, finds the start bit, samples at
// mid-bit and emits one-cycle valid / framing-error strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rx_rst,
  input  logic       rx_serial_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err
);

  localparam int         HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [12:0] HALF_LAST = 13'(HALF_BIT - 1);
  localparam logic [12:0] BIT_LAST  = 13'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS_N - 1);

  logic        rx_sync;
  logic [2:0]  state;
  logic [12:0] clk_count;
  logic [2:0]  bit_index;
  logic [7:0]  shift_reg;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rx_rst),
    .d   (rx_serial_in),
    .q   (rx_sync)
  );

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rx_rst) begin
      // NOTE: the shift register is a handful of flops, not a memory, so it
      // is reset along with everything else to give a fully known state.
      state        <= IDLE;
      clk_count    <= '0;
      bit_index    <= '0;
      shift_reg    <= '0;
      rx_data_out  <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      // Strobes default low so every pulse lasts exactly one cycle.
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          clk_count <= '0;
          bit_index <= '0;
          if (!rx_sync) state <= START_BIT;
        end
        START_BIT: begin
          if (clk_count == HALF_LAST) begin
            clk_count <= '0;
            state     <= rx_sync ? IDLE : DATA_BITS;
          end else begin
            clk_count <= clk_count + 13'd1;
          end
        end
        DATA_BITS: begin
          if (clk_count == BIT_LAST) begin
            clk_count            <= '0;
            shift_reg[bit_index] <= rx_sync;
            if (bit_index == LAST_IDX) begin
              bit_index <= '0;
              state     <= STOP_BIT;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            clk_count <= clk_count + 13'd1;
          end
        end
        STOP_BIT: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= '0;
            if (rx_sync) begin
              rx_data_out <= shift_reg;
              rx_valid    <= 1'b1;
              state       <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK_WAIT;
            end
          end else begin
            clk_count <= clk_count + 13'd1;
          end
        end
        // A held-low line must return high before another frame may start.
        BREAK_WAIT: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
